panxi_pipe_ctrl: RTL and testbench

Central pipeline sequencer for the PANXI RV32 core. It generates the 2-bit hold_en code for every inter-stage register and drives PC redirects. It arbitrates stage stall requests, taken-jump flushes and interrupt entry.
Stage registers are indexed 0 = IF/ID (youngest) to NSTAGE-1 = MEM/WB (oldest). hold_en codes are: 2'b00 pass, 2'b01 flush (load bubble), 2'b10 hold. Code 2'b11 is never driven.

---
 rtl/panxi_pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_panxi_pipe_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panxi_pipe_ctrl.sv
// panxi_pipe_ctrl -- central pipeline sequencer for the PANXI RV32 core.
//
// Produces a 2-bit hold_en code for every inter-stage register
// (00 pass, 01 flush/bubble, 10 hold; 11 never driven) and drives PC
// redirects.  It arbitrates per-stage stall requests, taken-jump flushes
// and interrupt entry.  Stage 0 is IF/ID (youngest), stage NSTAGE-1 is
// MEM/WB (oldest).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall_req       per-stage stall request, bit k from stage k
//   jump_req/addr   taken jump from EX and its target
//   irq_req/vector  level interrupt request and handler address
//   irq_ack         one-cycle pulse when the interrupt redirect is issued
//   hold_en         code for stage k at bits [2k+1:2k]
//   pc_hold         freeze the PC
//   pc_set/addr     load PC with pc_set_addr (addr is 0 when pc_set=0)
//   busy            sequencer is flushing, draining or entering an irq
//   stall_timeout   sticky stall watchdog flag
//
// Build option: define PANXI_STALL_WDT_EN to include the stall watchdog;
// without it stall_timeout is tied to 0.

module panxi_pipe_ctrl #(
  parameter int NSTAGE       = 4,
  parameter int JUMP_STAGE   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int AW           = 32,
  parameter int WDT_LIMIT    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSTAGE-1:0]   stall_req,
  input  logic                jump_req,
  input  logic [AW-1:0]       jump_addr,
  input  logic                irq_req,
  input  logic [AW-1:0]       irq_vector,
  output logic                irq_ack,
  output logic [2*NSTAGE-1:0] hold_en,
  output logic                pc_hold,
  output logic                pc_set,
  output logic [AW-1:0]       pc_set_addr,
  output logic                busy,
  output logic                stall_timeout
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_IRQ} state_t;

  localparam int CMAX = (FLUSH_CYCLES > NSTAGE) ? FLUSH_CYCLES : NSTAGE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(NSTAGE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;

  // stall_sfx[k] = some stage at index >= k requests a stall, i.e. stage k
  // lies at or below the highest stalling stage and must hold.
  logic [NSTAGE-1:0] stall_sfx;
  logic              stall_any;
  logic              jump_acc;
  logic              all_flush;
  logic              front_flush;
  logic              in_irq;

  assign stall_any   = stall_sfx[0];
  assign in_irq      = (state == ST_IRQ);
  // A jump can only be taken when nothing at or beyond the resolving stage
  // is stalled; the IRQ cycle flushes EX anyway, so a jump there is stale.
  assign jump_acc    = jump_req & ~stall_sfx[JUMP_STAGE] & ~rst & ~in_irq;
  assign all_flush   = rst | in_irq;
  assign front_flush = (state == ST_FLUSH) | (state == ST_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      localparam bit IN_JUMP = (gi <= JUMP_STAGE);
      logic base_flush;
      logic forced;

      assign stall_sfx[gi] = |(stall_req >> gi);

      if (gi == 0) begin : g_first
        // Stage 0 is also bubbled while fetch is being discarded/blocked.
        assign base_flush = 1'b0;
        assign forced     = all_flush | jump_acc | front_flush;
      end else begin : g_rest
        // The stage just above the highest stall receives a bubble.
        assign base_flush = stall_req[gi-1] & ~stall_sfx[gi];
        assign forced     = all_flush | (IN_JUMP ? jump_acc : 1'b0);
      end

      assign hold_en[2*gi +: 2] = forced        ? 2'b01 :
                                  stall_sfx[gi] ? 2'b10 :
                                  base_flush    ? 2'b01 : 2'b00;
    end
  endgenerate

  assign pc_hold = ~rst & stall_any & ~jump_acc & ~in_irq;
  assign pc_set  = ~rst & (jump_acc | in_irq);
  assign irq_ack = ~rst & in_irq;
  assign busy    = ~rst & (state != ST_RUN);

  always_comb begin
    pc_set_addr = '0;
    if (~rst & in_irq) begin
      pc_set_addr = irq_vector;
    end else if (jump_acc) begin
      pc_set_addr = jump_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // A simultaneous jump wins; the level irq is seen again later.
          if (jump_acc) begin
            if (FLUSH_CYCLES > 1) begin
              state <= ST_FLUSH;
              cnt   <= FLUSH_LOAD;
            end
          end else if (irq_req) begin
            state <= ST_DRAIN;
            cnt   <= DRAIN_LOAD;
          end
        end
        ST_FLUSH: begin
          if (jump_acc) begin
            cnt <= FLUSH_LOAD;
          end else if (cnt <= CNT_ONE) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (jump_acc) begin
            if (FLUSH_CYCLES > 1) begin
              state <= ST_FLUSH;
              cnt   <= FLUSH_LOAD;
            end else begin
              state <= ST_RUN;
            end
          end else if (!irq_req) begin
            state <= ST_RUN;
          end else if (!stall_any) begin
            // Only stall-free cycles move instructions toward writeback.
            if (cnt <= CNT_ONE) begin
              state <= ST_IRQ;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        ST_IRQ:  state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PANXI_STALL_WDT_EN
  localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);
  logic [15:0] wdt_cnt;
  logic        wdt_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else if (!stall_any) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_MAX) begin
      wdt_cnt <= wdt_cnt + 16'd1;
      if (wdt_cnt + 16'd1 == WDT_MAX) begin
        wdt_flag <= 1'b1;
      end
    end
  end

  assign stall_timeout = wdt_flag;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_panxi_pipe_ctrl.sv
// Self-checking bench for panxi_pipe_ctrl (NSTAGE=4, JUMP_STAGE=1,
// FLUSH_CYCLES=3, WDT_LIMIT=8).  Each scenario is a table of per-cycle
// stimulus rows carrying the expected outputs; the expectation is queued
// when the row is driven and popped when the outputs are sampled.

module tb_panxi_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stall_req;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic        irq_ack;
  logic [7:0]  hold_en;
  logic        pc_hold;
  logic        pc_set;
  logic [31:0] pc_set_addr;
  logic        busy;
  logic        stall_timeout;

  typedef struct packed {
    logic [7:0]  hold;
    logic        ph;
    logic        ps;
    logic [31:0] addr;
    logic        busy;
    logic        ack;
    logic        to;
  } obs_t;

  typedef struct packed {
    logic        r;
    logic [3:0]  s;
    logic        j;
    logic [31:0] ja;
    logic        i;
    obs_t        exp;
  } stim_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  panxi_pipe_ctrl #(
    .NSTAGE(4), .JUMP_STAGE(1), .FLUSH_CYCLES(3), .AW(32), .WDT_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .jump_req(jump_req),
    .jump_addr(jump_addr), .irq_req(irq_req), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .hold_en(hold_en), .pc_hold(pc_hold), .pc_set(pc_set),
    .pc_set_addr(pc_set_addr), .busy(busy), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic r, logic [3:0] s, logic j, logic [31:0] ja,
                               logic i, logic [7:0] h, logic ph, logic ps,
                               logic [31:0] a, logic b, logic ak, logic to);
    stim_t x;
    x.r = r; x.s = s; x.j = j; x.ja = ja; x.i = i;
    x.exp = '{hold: h, ph: ph, ps: ps, addr: a, busy: b, ack: ak, to: to};
    return x;
  endfunction

  // Drive one row's inputs and queue what the outputs must be this cycle.
  task automatic apply(input stim_t x);
    rst       = x.r;
    stall_req = x.s;
    jump_req  = x.j;
    jump_addr = x.ja;
    irq_req   = x.i;
    exp_q.push_back(x.exp);
  endtask

  task automatic test_reset;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(1, 4'b0000, 0, 32'h0,   0, 8'h55, 0, 0, 32'h0, 0, 0, 0),
      mk(1, 4'b0010, 1, 32'h100, 1, 8'h55, 0, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0, 0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0010, 0, 32'h0, 0, 8'h1A, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0010, 0, 32'h0, 0, 8'h1A, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0010, 0, 32'h0, 0, 8'h1A, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b1000, 0, 32'h0, 0, 8'hAA, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0001, 0, 32'h0, 0, 8'h06, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0101, 0, 32'h0, 0, 8'h6A, 1, 0, 32'h0, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  // Accept, flush window with a stall inside it, jump with a stage-0-only
  // stall, and a second jump reloading the flush window.
  task automatic test_jump;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0000, 1, 32'h100, 0, 8'h05, 0, 1, 32'h100, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0100, 0, 32'h0,   0, 8'h69, 1, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0001, 1, 32'h200, 0, 8'h05, 0, 1, 32'h200, 0, 0, 0),
      mk(0, 4'b0000, 1, 32'h300, 0, 8'h05, 0, 1, 32'h300, 1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jump[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_blocked;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0100, 1, 32'h400, 0, 8'h6A, 1, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0010, 1, 32'h400, 0, 8'h1A, 1, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 1, 32'h400, 0, 8'h05, 0, 1, 32'h400, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jump_blocked[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset abandons a flush and a drain; irq dropping mid-drain returns to RUN.
  task automatic test_reset_abort;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0000, 1, 32'h500, 0, 8'h05, 0, 1, 32'h500, 0, 0, 0),
      mk(1, 4'b0000, 0, 32'h0,   0, 8'h55, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(1, 4'b0000, 0, 32'h0,   1, 8'h55, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_abort[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  // irq raised in RUN; drain spans 3 stall-free + 2 stalled cycles, then the
  // single IRQ cycle redirects to the vector.
  task automatic test_irq;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0000, 0, 32'h0, 1, 8'h00, 0, 0, 32'h0,  0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 1, 8'h01, 0, 0, 32'h0,  1, 0, 0),
      mk(0, 4'b1000, 0, 32'h0, 1, 8'hA9, 1, 0, 32'h0,  1, 0, 0),
      mk(0, 4'b1000, 0, 32'h0, 1, 8'hA9, 1, 0, 32'h0,  1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 1, 8'h01, 0, 0, 32'h0,  1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 1, 8'h01, 0, 0, 32'h0,  1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0, 0, 8'h55, 0, 1, 32'h80, 1, 1, 0),
      mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0,  0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL irq[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  // Jump and irq together in RUN (jump first), then a jump interrupting the
  // drain, after which the drain restarts from scratch.
  task automatic test_jump_irq;
    stim_t rows[$];
    obs_t  got, want;
    rows = '{
      mk(0, 4'b0000, 1, 32'h600, 1, 8'h05, 0, 1, 32'h600, 0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 1, 32'h700, 1, 8'h05, 0, 1, 32'h700, 1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h00, 0, 0, 32'h0,   0, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   1, 8'h01, 0, 0, 32'h0,   1, 0, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h55, 0, 1, 32'h80,  1, 1, 0),
      mk(0, 4'b0000, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   0, 0, 0)
    };
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jump_irq[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  // stall_req[0] held 8 cycles; with the watchdog built in and a limit of 8
  // the flag is visible from the cycle after the 8th stalled edge and
  // persists until reset; without it the flag never rises.
  task automatic test_wdt;
    stim_t rows[$];
    obs_t  got, want;
    logic  t;
`ifdef PANXI_STALL_WDT_EN
    t = 1'b1;
`else
    t = 1'b0;
`endif
    for (int k = 0; k < 8; k++) begin
      rows.push_back(mk(0, 4'b0001, 0, 32'h0, 0, 8'h06, 1, 0, 32'h0, 0, 0, 0));
    end
    rows.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 0, 0, t));
    rows.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 0, 0, t));
    rows.push_back(mk(1, 4'b0000, 0, 32'h0, 0, 8'h55, 0, 0, 32'h0, 0, 0, t));
    rows.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0));
    foreach (rows[n]) begin
      apply(rows[n]);
      @(negedge clk);
      got  = {hold_en, pc_hold, pc_set, pc_set_addr, busy, irq_ack, stall_timeout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wdt[%0d]: got hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b, want hold=%h ph=%b ps=%b addr=%h busy=%b ack=%b to=%b",
                 n, got.hold, got.ph, got.ps, got.addr, got.busy, got.ack, got.to,
                 want.hold, want.ph, want.ps, want.addr, want.busy, want.ack, want.to);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    stall_req  = '0;
    jump_req   = 1'b0;
    jump_addr  = '0;
    irq_req    = 1'b0;
    irq_vector = 32'h0000_0080;
    @(posedge clk); #1;
    test_reset();
    test_stall();
    test_jump();
    test_jump_blocked();
    test_reset_abort();
    test_irq();
    test_jump_irq();
    test_wdt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
